// File: rtl/man_pix_sched.sv
// man_pix_sched: frame sequencer for the Mandelbrot datapath.
// A rising edge on init walks every pixel of an HRES x VRES frame in raster
// order, issuing one coordinate/address request per pixel to the iteration
// engine and counting the results that come back. done is raised once all
// results of the frame have arrived.
// Optional feature: define MAN_PIX_SCHED_PERF_EN to measure the frame duration
// on frame_cycles; without it frame_cycles is tied to 0.
module man_pix_sched #(
  parameter int FPW  = 54,
  parameter int HRES = 800,
  parameter int VRES = 600,
  parameter int HW   = 10,
  parameter int VW   = 10,
  parameter int AW   = 19
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           init,
  input  logic [FPW-1:0] x0,
  input  logic [FPW-1:0] y0,
  input  logic [FPW-1:0] xs,
  input  logic [FPW-1:0] ys,
  output logic           req_vld,
  input  logic           req_rdy,
  output logic [FPW-1:0] req_x,
  output logic [FPW-1:0] req_y,
  output logic [AW-1:0]  req_adr,
  input  logic           res_vld,
  output logic           busy,
  output logic           done,
  output logic [31:0]    frame_cycles
);

  // one extra bit so the completion counter can hold HRES*VRES even when
  // that equals 2^AW
  localparam int            CW        = AW + 1;
  localparam logic [CW-1:0] PIX_TOTAL = CW'(HRES * VRES);
  localparam logic [HW-1:0] COL_LAST  = HW'(HRES - 1);
  localparam logic [VW-1:0] ROW_LAST  = VW'(VRES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic           init_q, init_d;
  logic           armed_q, armed_d;
  logic [FPW-1:0] x0_q, x0_d;
  logic [FPW-1:0] xs_q, xs_d;
  logic [FPW-1:0] ys_q, ys_d;
  logic [FPW-1:0] cur_x_q, cur_x_d;
  logic [FPW-1:0] cur_y_q, cur_y_d;
  logic [HW-1:0]  col_q, col_d;
  logic [VW-1:0]  row_q, row_d;
  logic [AW-1:0]  adr_q, adr_d;
  logic [CW-1:0]  completed_q, completed_d;
  logic           start;
  logic           res_take;
  logic           last_pix;

  // init edge detect; armed only becomes set once init has been seen low,
  // so an init level that is already high when reset releases starts nothing
  always_comb begin
    init_d  = init;
    armed_d = armed_q | ~init;
    start   = init & ~init_q & armed_q;
  end

  // frame sequencing: next state, pixel walk and result counting
  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    xs_d        = xs_q;
    ys_d        = ys_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    col_d       = col_q;
    row_d       = row_q;
    adr_d       = adr_q;
    completed_d = completed_q;
    res_take    = res_vld && (completed_q != PIX_TOTAL);
    last_pix    = (col_q == COL_LAST) && (row_q == ROW_LAST);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
        end
      end

      LOAD: begin
        x0_d        = x0;
        xs_d        = xs;
        ys_d        = ys;
        cur_x_d     = x0;
        cur_y_d     = y0;
        col_d       = '0;
        row_d       = '0;
        adr_d       = '0;
        completed_d = '0;
        state_d     = ISSUE;
      end

      ISSUE: begin
        if (start) begin
          state_d = LOAD;
        end else begin
          if (res_take) begin
            completed_d = completed_q + CW'(1);
          end
          if (req_rdy) begin
            if (last_pix) begin
              state_d = DRAIN;
            end else if (col_q == COL_LAST) begin
              col_d   = '0;
              cur_x_d = x0_q;
              row_d   = row_q + VW'(1);
              cur_y_d = cur_y_q + ys_q;
              adr_d   = adr_q + AW'(1);
            end else begin
              col_d   = col_q + HW'(1);
              cur_x_d = cur_x_q + xs_q;
              adr_d   = adr_q + AW'(1);
            end
          end
        end
      end

      DRAIN: begin
        if (start) begin
          state_d = LOAD;
        end else begin
          if (res_take) begin
            completed_d = completed_q + CW'(1);
          end
          if (completed_d == PIX_TOTAL) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        if (start) begin
          state_d = LOAD;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      init_q      <= 1'b0;
      armed_q     <= 1'b0;
      x0_q        <= '0;
      xs_q        <= '0;
      ys_q        <= '0;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      adr_q       <= '0;
      completed_q <= '0;
    end else begin
      state_q     <= state_d;
      init_q      <= init_d;
      armed_q     <= armed_d;
      x0_q        <= x0_d;
      xs_q        <= xs_d;
      ys_q        <= ys_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      col_q       <= col_d;
      row_q       <= row_d;
      adr_q       <= adr_d;
      completed_q <= completed_d;
    end
  end

  // request and status outputs follow the registered state directly
  always_comb begin
    req_vld = (state_q == ISSUE);
    req_x   = cur_x_q;
    req_y   = cur_y_q;
    req_adr = adr_q;
    busy    = (state_q == LOAD) || (state_q == ISSUE) || (state_q == DRAIN);
    done    = (state_q == DONE);
  end

`ifdef MAN_PIX_SCHED_PERF_EN
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] fcyc_q, fcyc_d;

  // saturating frame-duration counter, captured when the frame completes
  always_comb begin
    cyc_d  = cyc_q;
    fcyc_d = fcyc_q;
    if (state_q == LOAD) begin
      cyc_d = '0;
    end else if (((state_q == ISSUE) || (state_q == DRAIN)) && (cyc_q != 32'hffff_ffff)) begin
      cyc_d = cyc_q + 32'd1;
    end
    if ((state_q == DRAIN) && (state_d == DONE)) begin
      fcyc_d = cyc_d;
    end
  end

  // performance counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q  <= '0;
      fcyc_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      fcyc_q <= fcyc_d;
    end
  end

  assign frame_cycles = fcyc_q;
`else
  assign frame_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_man_pix_sched.sv
// Bench for man_pix_sched on a small 4x3 frame. The engine model answers
// every accepted request with one res_vld pulse four cycles after the
// handshake cycle; expected requests are queued per frame and popped on
// each handshake.
module tb_man_pix_sched;

  localparam int FPW  = 16;
  localparam int HRES = 4;
  localparam int VRES = 3;
  localparam int HW   = 3;
  localparam int VW   = 2;
  localparam int AW   = 4;
  localparam int NPIX = HRES * VRES;

`ifdef MAN_PIX_SCHED_PERF_EN
  localparam logic [31:0] EXP_FC = 32'd16;
`else
  localparam logic [31:0] EXP_FC = 32'd0;
`endif

  typedef struct packed {
    logic [FPW-1:0] x;
    logic [FPW-1:0] y;
    logic [AW-1:0]  adr;
  } req_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           init;
  logic [FPW-1:0] x0, y0, xs, ys;
  logic           req_vld;
  logic           req_rdy;
  logic [FPW-1:0] req_x, req_y;
  logic [AW-1:0]  req_adr;
  logic           res_vld;
  logic           busy, done;
  logic [31:0]    frame_cycles;

  int   checks = 0;
  int   errors = 0;
  bit   hs;
  bit   rand_rdy;
  bit   inj_res;
  bit   [3:0] pipe;
  req_t exp_q[$];

  man_pix_sched #(
    .FPW (FPW),
    .HRES(HRES),
    .VRES(VRES),
    .HW  (HW),
    .VW  (VW),
    .AW  (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .init        (init),
    .x0          (x0),
    .y0          (y0),
    .xs          (xs),
    .ys          (ys),
    .req_vld     (req_vld),
    .req_rdy     (req_rdy),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_adr     (req_adr),
    .res_vld     (res_vld),
    .busy        (busy),
    .done        (done),
    .frame_cycles(frame_cycles)
  );

  always #5 clk = ~clk;

  // advance to the middle of the next cycle and drive the engine side
  task automatic tick();
    @(negedge clk);
    req_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    hs      = req_vld && req_rdy;
    res_vld = pipe[3] | inj_res;
    pipe    = {pipe[2:0], hs};
  endtask

  // expected request sequence of a whole frame
  task automatic push_frame(input logic [FPW-1:0] bx, input logic [FPW-1:0] by,
                            input logic [FPW-1:0] sx, input logic [FPW-1:0] sy);
    req_t e;
    exp_q.delete();
    for (int r = 0; r < VRES; r++) begin
      for (int c = 0; c < HRES; c++) begin
        e.x   = bx + FPW'(c) * sx;
        e.y   = by + FPW'(r) * sy;
        e.adr = AW'(r * HRES + c);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic test_reset();
    $display("[TB] reset values");
    repeat (2) @(negedge clk);
    checks++;
    if ({req_vld, busy, done} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got vld/busy/done %b expected 000", {req_vld, busy, done});
    end
    checks++;
    if (req_x !== '0) begin
      errors++;
      $display("[TB] FAIL reset_req_x: got %h expected 0", req_x);
    end
    checks++;
    if (req_y !== '0) begin
      errors++;
      $display("[TB] FAIL reset_req_y: got %h expected 0", req_y);
    end
    checks++;
    if (req_adr !== '0) begin
      errors++;
      $display("[TB] FAIL reset_req_adr: got %0d expected 0", req_adr);
    end
    checks++;
    if (frame_cycles !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_frame_cycles: got %0d expected 0", frame_cycles);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_frame();
    int   res_cnt = 0;
    int   hs_cnt = 0;
    int   first_hs = -1;
    int   last_hs = -1;
    int   res12 = -1;
    int   done_at = -1;
    bit   done_ok = 1'b1;
    req_t e;
    $display("[TB] basic frame with stray results");
    rand_rdy = 1'b0;
    inj_res  = 1'b1;
    tick();
    tick();
    inj_res = 1'b0;
    x0 = 16'h0010; y0 = 16'h0100; xs = 16'h0002; ys = 16'h0020;
    push_frame(x0, y0, xs, ys);
    init = 1'b1;
    tick();
    init = 1'b0;
    for (int t = 0; t < 100 && done_at < 0; t++) begin
      tick();
      if (hs) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL frame_extra_req: got adr %0d expected no request", req_adr);
        end else begin
          e = exp_q.pop_front();
          if ({req_x, req_y, req_adr} !== {e.x, e.y, e.adr}) begin
            errors++;
            $display("[TB] FAIL frame_req: got x=%h y=%h adr=%0d expected x=%h y=%h adr=%0d",
                     req_x, req_y, req_adr, e.x, e.y, e.adr);
          end
        end
        if (first_hs < 0) first_hs = t;
        last_hs = t;
        hs_cnt++;
      end
      if (res_vld) begin
        res_cnt++;
        if (res_cnt == NPIX) res12 = t;
      end
      if (done) done_at = t;
    end
    checks++;
    if (done_at < 0 || done_at != res12 + 1) begin
      errors++;
      $display("[TB] FAIL frame_done_timing: got cycle %0d expected %0d", done_at, res12 + 1);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL frame_busy_at_done: got %b expected 0", busy);
    end
    checks++;
    if (hs_cnt != NPIX || last_hs - first_hs != NPIX - 1) begin
      errors++;
      $display("[TB] FAIL frame_b2b: got %0d reqs over %0d cycles expected %0d over %0d",
               hs_cnt, last_hs - first_hs + 1, NPIX, NPIX);
    end
    checks++;
    if (frame_cycles !== EXP_FC) begin
      errors++;
      $display("[TB] FAIL frame_cycles: got %0d expected %0d", frame_cycles, EXP_FC);
    end
    inj_res = 1'b1;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (t == 2) inj_res = 1'b0;
      if (done !== 1'b1 || busy !== 1'b0 || req_vld !== 1'b0) done_ok = 1'b0;
    end
    checks++;
    if (!done_ok) begin
      errors++;
      $display("[TB] FAIL late_results: got done/busy/vld %b expected 100", {done, busy, req_vld});
    end
    checks++;
    if (frame_cycles !== EXP_FC) begin
      errors++;
      $display("[TB] FAIL late_frame_cycles: got %0d expected %0d", frame_cycles, EXP_FC);
    end
  endtask

  task automatic test_abort();
    int   hs_cnt = 0;
    int   res_cnt = 0;
    int   res12 = -1;
    int   done_at = -1;
    req_t e;
    $display("[TB] abort and restart");
    rand_rdy = 1'b0;
    push_frame(x0, y0, xs, ys);
    init = 1'b1;
    tick();
    init = 1'b0;
    checks++;
    if ({done, busy, req_vld} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL restart_load: got done/busy/vld %b expected 010", {done, busy, req_vld});
    end
    for (int t = 0; t < 20 && hs_cnt < 5; t++) begin
      tick();
      if (hs) begin
        e = exp_q.pop_front();
        checks++;
        if ({req_x, req_y, req_adr} !== {e.x, e.y, e.adr}) begin
          errors++;
          $display("[TB] FAIL abort_old_req: got x=%h adr=%0d expected x=%h adr=%0d",
                   req_x, req_adr, e.x, e.adr);
        end
        hs_cnt++;
      end
    end
    x0   = 16'h0040;
    init = 1'b1;
    tick();
    init = 1'b0;
    checks++;
    if (req_vld !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_drop: got vld/busy %b expected 01", {req_vld, busy});
    end
    checks++;
    if (frame_cycles !== EXP_FC) begin
      errors++;
      $display("[TB] FAIL abort_frame_cycles_hold: got %0d expected %0d", frame_cycles, EXP_FC);
    end
    pipe   = '0;
    hs_cnt = 0;
    push_frame(x0, y0, xs, ys);
    for (int t = 0; t < 100 && done_at < 0; t++) begin
      tick();
      if (hs) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL abort_extra_req: got adr %0d expected no request", req_adr);
        end else begin
          e = exp_q.pop_front();
          if ({req_x, req_y, req_adr} !== {e.x, e.y, e.adr}) begin
            errors++;
            $display("[TB] FAIL abort_new_req: got x=%h y=%h adr=%0d expected x=%h y=%h adr=%0d",
                     req_x, req_y, req_adr, e.x, e.y, e.adr);
          end
        end
        hs_cnt++;
      end
      if (res_vld) begin
        res_cnt++;
        if (res_cnt == NPIX) res12 = t;
      end
      if (done) done_at = t;
    end
    checks++;
    if (done_at < 0 || done_at != res12 + 1 || hs_cnt != NPIX) begin
      errors++;
      $display("[TB] FAIL abort_done_timing: got cycle %0d reqs %0d expected cycle %0d reqs %0d",
               done_at, hs_cnt, res12 + 1, NPIX);
    end
    checks++;
    if (frame_cycles !== EXP_FC) begin
      errors++;
      $display("[TB] FAIL abort_frame_cycles: got %0d expected %0d", frame_cycles, EXP_FC);
    end
  endtask

  task automatic test_stall();
    int             hs_cnt = 0;
    int             res_cnt = 0;
    int             res12 = -1;
    int             done_at = -1;
    logic [AW-1:0]  last_adr = '0;
    bit             prev_stall = 1'b0;
    logic [FPW-1:0] px, py;
    logic [AW-1:0]  pa;
    req_t           e;
    $display("[TB] random backpressure");
    x0 = 16'h0010;
    push_frame(x0, y0, xs, ys);
    rand_rdy = 1'b1;
    init = 1'b1;
    tick();
    init = 1'b0;
    px = '0; py = '0; pa = '0;
    for (int t = 0; t < 400 && done_at < 0; t++) begin
      tick();
      if (prev_stall) begin
        checks++;
        if (req_vld !== 1'b1 || {req_x, req_y, req_adr} !== {px, py, pa}) begin
          errors++;
          $display("[TB] FAIL stall_hold: got vld=%b x=%h y=%h adr=%0d expected vld=1 x=%h y=%h adr=%0d",
                   req_vld, req_x, req_y, req_adr, px, py, pa);
        end
      end
      if (hs) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL stall_extra_req: got adr %0d expected no request", req_adr);
        end else begin
          e = exp_q.pop_front();
          if ({req_x, req_y, req_adr} !== {e.x, e.y, e.adr}) begin
            errors++;
            $display("[TB] FAIL stall_req: got x=%h y=%h adr=%0d expected x=%h y=%h adr=%0d",
                     req_x, req_y, req_adr, e.x, e.y, e.adr);
          end
        end
        last_adr = req_adr;
        hs_cnt++;
      end
      prev_stall = req_vld && !req_rdy;
      px = req_x; py = req_y; pa = req_adr;
      if (res_vld) begin
        res_cnt++;
        if (res_cnt == NPIX) res12 = t;
      end
      if (done) done_at = t;
    end
    rand_rdy = 1'b0;
    checks++;
    if (hs_cnt != NPIX || last_adr != AW'(NPIX - 1) || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL stall_count: got %0d reqs last adr %0d expected %0d reqs last adr %0d",
               hs_cnt, last_adr, NPIX, NPIX - 1);
    end
    checks++;
    if (done_at < 0 || done_at != res12 + 1) begin
      errors++;
      $display("[TB] FAIL stall_done_timing: got cycle %0d expected %0d", done_at, res12 + 1);
    end
  endtask

  task automatic test_wrap();
    int             hs_cnt = 0;
    logic [FPW-1:0] row0 [HRES];
    logic [FPW-1:0] want [HRES];
    req_t           e;
    $display("[TB] coordinate wrap");
    want = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    x0 = 16'hFFFE; y0 = 16'h0000; xs = 16'h0001; ys = 16'h0010;
    push_frame(x0, y0, xs, ys);
    init = 1'b1;
    tick();
    init = 1'b0;
    for (int t = 0; t < 40 && hs_cnt < NPIX; t++) begin
      tick();
      if (hs) begin
        e = exp_q.pop_front();
        checks++;
        if ({req_x, req_y, req_adr} !== {e.x, e.y, e.adr}) begin
          errors++;
          $display("[TB] FAIL wrap_req: got x=%h y=%h adr=%0d expected x=%h y=%h adr=%0d",
                   req_x, req_y, req_adr, e.x, e.y, e.adr);
        end
        if (hs_cnt < HRES) row0[hs_cnt] = req_x;
        hs_cnt++;
      end
    end
    for (int i = 0; i < HRES; i++) begin
      checks++;
      if (hs_cnt < HRES || row0[i] !== want[i]) begin
        errors++;
        $display("[TB] FAIL wrap_row0: got %h at col %0d expected %h", row0[i], i, want[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit idle_ok = 1'b1;
    $display("[TB] reset during drain");
    tick();
    checks++;
    if (busy !== 1'b1 || req_vld !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drain_state: got busy/vld %b expected 10", {busy, req_vld});
    end
    init = 1'b1;
    rst  = 1'b1;
    #1;
    checks++;
    if ({req_vld, busy, done} !== 3'b000 || req_x !== '0 || req_y !== '0 ||
        req_adr !== '0 || frame_cycles !== 32'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got vld/busy/done %b x=%h y=%h adr=%0d fc=%0d expected all 0",
               {req_vld, busy, done}, req_x, req_y, req_adr, frame_cycles);
    end
    pipe = '0;
    tick();
    rst = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick();
      if (busy !== 1'b0 || req_vld !== 1'b0) idle_ok = 1'b0;
    end
    checks++;
    if (!idle_ok) begin
      errors++;
      $display("[TB] FAIL init_held_start: got busy/vld %b expected 00", {busy, req_vld});
    end
    init = 1'b0;
    tick();
    init = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1 || req_vld !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rearm_load: got busy/vld %b expected 10", {busy, req_vld});
    end
    init = 1'b0;
    tick();
    checks++;
    if (req_vld !== 1'b1 || req_adr !== '0 || req_x !== 16'hFFFE) begin
      errors++;
      $display("[TB] FAIL rearm_first_req: got vld=%b adr=%0d x=%h expected vld=1 adr=0 x=fffe",
               req_vld, req_adr, req_x);
    end
  endtask

  initial begin
    rst      = 1'b1;
    init     = 1'b0;
    req_rdy  = 1'b0;
    res_vld  = 1'b0;
    x0       = '0;
    y0       = '0;
    xs       = '0;
    ys       = '0;
    hs       = 1'b0;
    rand_rdy = 1'b0;
    inj_res  = 1'b0;
    pipe     = '0;
    test_reset();
    test_frame();
    test_abort();
    test_stall();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/man_pix_sched.md
Name: man_pix_sched

Overview:
- Frame sequencer for the Mandelbrot datapath. On a rising edge of the init level from the control registers, it walks every pixel of an HRES x VRES frame in raster order.
- For each pixel it issues one coordinate/address request to the iteration engine over a valid/ready handshake, then counts returned results.
- Asserts done when the whole frame has completed. Sits between the control register block (man_init/man_x0/man_y0/man_xs/man_ys in, man_done out) and the iteration engine.

Parameters:
- FPW, 54, fixed-point width of coordinates and steps (two's complement).
- HRES, 800, pixels per row.
- VRES, 600, rows per frame.
- HW, 10, column counter width; must satisfy 2^HW > HRES.
- VW, 10, row counter width; must satisfy 2^VW > VRES.
- AW, 19, pixel address width; must satisfy 2^AW >= HRES*VRES.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- init  in  1  start level from the control registers; the rising edge starts a frame.
- x0  in  FPW  real coordinate of column 0.
- y0  in  FPW  imaginary coordinate of row 0.
- xs  in  FPW  real step per column.
- ys  in  FPW  imaginary step per row.
- req_vld  out  1  request valid.
- req_rdy  in  1  engine accepts the request.
- req_x  out  FPW  pixel real coordinate.
- req_y  out  FPW  pixel imaginary coordinate.
- req_adr  out  AW  linear pixel address, row*HRES+col.
- res_vld  in  1  one-cycle pulse per completed pixel result.
- busy  out  1  frame in progress.
- done  out  1  frame complete (level).
- frame_cycles  out  32  frame duration; see Optional Feature.

Behaviour:
- Reset values:
  - All outputs 0: req_vld, req_x, req_y, req_adr, busy, done, frame_cycles.
  - FSM in IDLE; init edge register = 0.
- Init edge detection:
  - init_d <= init; start = init & ~init_d.
  - An init already high when reset releases does not start a frame.
- FSM states: IDLE, LOAD, ISSUE, DRAIN, DONE.
- IDLE: start -> LOAD.
- LOAD (1 cycle):
  - Latch x0, y0, xs, ys into internal registers; later input changes do not affect the running frame.
  - Set cur_x=x0, cur_y=y0, col=0, row=0, adr=0, issued=0, completed=0.
  - Clear done. Set busy=1. Go to ISSUE.
- ISSUE:
  - req_vld=1 with req_x=cur_x, req_y=cur_y, req_adr=adr.
  - While req_vld && !req_rdy, all req_* outputs hold stable.
  - On handshake (req_vld && req_rdy):
    - If col==HRES-1: col=0, cur_x=x0_latched, row+=1, cur_y+=ys.
    - Otherwise: col+=1, cur_x+=xs.
    - adr+=1 in both cases.
  - Back-to-back handshakes give one request per cycle; the next request is presented in the cycle after the handshake with no bubble.
  - When the handshake of pixel (HRES-1, VRES-1) occurs: req_vld=0 next cycle, go to DRAIN.
- Arithmetic: coordinate adds are FPW-bit two's complement, wrapping modulo 2^FPW, no saturation.
- DRAIN: wait until completed == HRES*VRES, then go to DONE.
- DONE: done=1, busy=0. Hold until the next start, then go to LOAD.
- res_vld handling:
  - Counted in ISSUE and DRAIN only; ignored in IDLE, LOAD, DONE.
  - Pulses beyond HRES*VRES in a frame are ignored; the counter saturates.
  - res_vld coincident with a handshake: both take effect in the same cycle.
- Start in ISSUE or DRAIN:
  - Abort the current frame, drop req_vld next cycle, go to LOAD.
  - The in-flight frame's results are discarded because the counters are reset.
  - The engine must tolerate a request being withdrawn after an abort; this is the only case where req_vld falls without a handshake.
- Start in DONE: go to LOAD; done falls in the LOAD cycle.
- Reset mid-frame: immediate return to reset values.

Optional Feature:
- Macro MAN_PIX_SCHED_PERF_EN.
- When defined:
  - 32-bit counter clears in LOAD and increments every cycle in ISSUE and DRAIN, saturating at 32'hffffffff.
  - frame_cycles is updated with the count on entry to DONE and holds until the next DONE entry.
  - frame_cycles keeps its last value across an aborted frame.
- When not defined: no counter logic; frame_cycles is constant 0.

Test Plan:
- HRES=4, VRES=3, x0=0x10, y0=0x100, xs=2, ys=0x20, req_rdy=1, one res_vld per accepted request with a 3-cycle delay:
  - Expect 12 consecutive requests.
  - Expected values: req_x=0x10,0x12,0x14,0x16 per row; req_y=0x100,0x120,0x140; req_adr=0..11.
  - done rises 1 cycle after the 12th res_vld; busy falls with it.
- Same setup, req_rdy toggling randomly:
  - req_x/req_y/req_adr stable while stalled.
  - No address skipped or duplicated.
  - Final adr=11.
- Coordinate wrap: x0=2^FPW-2, xs=1, HRES=4 -> row 0 req_x = 2^FPW-2, 2^FPW-1, 0, 1.
- Abort: raise init again after 5 handshakes:
  - req_vld low next cycle, then LOAD.
  - Restart from adr=0 with the new x0.
  - done asserts only after 12 results of the new frame; old results arriving during LOAD are ignored.
- Extra/early results: 2 res_vld pulses in IDLE and 3 pulses after completion -> no effect on done timing or counter; done stays 1.
- Reset: assert rst during DRAIN -> all outputs 0 immediately; init held high through reset release starts nothing until init goes low then high.
- With MAN_PIX_SCHED_PERF_EN: the first scenario yields frame_cycles equal to the number of cycles spent in ISSUE+DRAIN (12 issue + 3 drain-latency + 1 = 16). Without the macro, frame_cycles = 0.
